// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the sequential ALU/mul-div unit.
// The master side issues operations; the slave side returns registered results.
interface alu_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      alu_ctrl;
  logic            kill;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, a, b, alu_ctrl, kill,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, a, b, alu_ctrl, kill,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Integer ALU with single-cycle base ops and an iterative RV M-extension unit
// (radix-2 shift-add multiplier, restoring divider) behind a valid/ready handshake.
module alu_muldiv_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input logic clk,
  input logic rst,
  alu_muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL_ITER, DIV_ITER, FIN} state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_next;
  logic [SHW:0]    counter;
  logic [3:0]      op;
  logic            neg_res;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] prod_hi;
  logic [XLEN-1:0] prod_lo;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            out_valid_q;
  logic            in_ready_c;
  logic            busy_c;

  logic            accept;
  logic            is_mul, is_div;
  logic            a_signed, b_signed, a_neg, b_neg, load_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_special;
  logic [XLEN-1:0] special_result;
  logic [XLEN-1:0] base_result;
  logic [SHW-1:0]  shamt;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_shift;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ok;

  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quo_fixed, rem_fixed;
  logic [XLEN-1:0]   fin_result;

  assign accept = bus.in_valid && (state == IDLE) && !bus.kill;
  assign is_mul = (bus.alu_ctrl[3:2] == 2'b10);
  assign is_div = (bus.alu_ctrl[3:2] == 2'b11);
  assign shamt  = bus.b[SHW-1:0];

  always_comb begin
    base_result = '0;
    case (bus.alu_ctrl[2:0])
      3'd0:    base_result = bus.a + bus.b;
      3'd1:    base_result = bus.a - bus.b;
      3'd2:    base_result = bus.a & bus.b;
      3'd3:    base_result = bus.a | bus.b;
      3'd4:    base_result = bus.a ^ bus.b;
      3'd5:    base_result = bus.a << shamt;
      3'd6:    base_result = bus.a >> shamt;
      default: base_result = $unsigned($signed(bus.a) >>> shamt);
    endcase
  end

  // Operands are converted to magnitudes; the sign is reapplied once in FIN.
  always_comb begin
    a_signed       = (bus.alu_ctrl == 4'b1001) || (bus.alu_ctrl == 4'b1010) ||
                     (is_div && !bus.alu_ctrl[0]);
    b_signed       = (bus.alu_ctrl == 4'b1001) || (is_div && !bus.alu_ctrl[0]);
    a_neg          = a_signed && bus.a[XLEN-1];
    b_neg          = b_signed && bus.b[XLEN-1];
    a_mag          = a_neg ? ('0 - bus.a) : bus.a;
    b_mag          = b_neg ? ('0 - bus.b) : bus.b;
    load_neg       = (is_div && bus.alu_ctrl[1]) ? a_neg : (a_neg ^ b_neg);
    div_special    = is_div && ((bus.b == '0) ||
                     (!bus.alu_ctrl[0] && (bus.a == MIN_INT) && (bus.b == '1)));
    special_result = (bus.b == '0) ? (bus.alu_ctrl[1] ? bus.a : '1)
                                   : (bus.alu_ctrl[1] ? '0 : MIN_INT);
  end

  always_comb begin
    mul_sum   = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    mul_shift = {mul_sum, prod_lo[XLEN-1:1]};
    div_shift = {prod_hi, prod_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    div_ok    = !div_diff[XLEN];
  end

  always_comb begin
    prod_fixed = neg_res ? ('0 - {prod_hi, prod_lo}) : {prod_hi, prod_lo};
    quo_fixed  = neg_res ? ('0 - prod_lo) : prod_lo;
    rem_fixed  = neg_res ? ('0 - prod_hi) : prod_hi;
    case (op)
      4'b1000:                   fin_result = prod_fixed[XLEN-1:0];
      4'b1001, 4'b1010, 4'b1011: fin_result = prod_fixed[2*XLEN-1:XLEN];
      4'b1100, 4'b1101:          fin_result = quo_fixed;
      default:                   fin_result = rem_fixed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (accept && is_mul)                     state_next = MUL_ITER;
        else if (accept && is_div && !div_special) state_next = DIV_ITER;
      end
      MUL_ITER, DIV_ITER: begin
        busy_c = 1'b1;
        if (counter == (SHW+1)'(1)) state_next = FIN;
      end
      default: begin
        busy_c     = 1'b1;
        state_next = IDLE;
      end
    endcase
    if (bus.kill && (state != IDLE)) state_next = IDLE;
  end

  // Multiplier keeps {prod_hi, prod_lo} as the shifting product; the divider reuses
  // prod_hi as the partial remainder and prod_lo as dividend-in/quotient-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= '0;
      op          <= '0;
      neg_res     <= 1'b0;
      mcand       <= '0;
      prod_hi     <= '0;
      prod_lo     <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op <= bus.alu_ctrl;
            if (!bus.alu_ctrl[3]) begin
              result_q    <= base_result;
              zero_q      <= (base_result == '0);
              out_valid_q <= 1'b1;
            end else if (div_special) begin
              result_q    <= special_result;
              zero_q      <= (special_result == '0);
              out_valid_q <= 1'b1;
            end else begin
              mcand   <= b_mag;
              prod_hi <= '0;
              prod_lo <= a_mag;
              neg_res <= load_neg;
              counter <= (SHW+1)'(XLEN);
            end
          end
        end
        MUL_ITER: begin
          prod_hi <= mul_shift[2*XLEN-1:XLEN];
          prod_lo <= mul_shift[XLEN-1:0];
          counter <= counter - 1'b1;
        end
        DIV_ITER: begin
          prod_hi <= div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
          prod_lo <= {prod_lo[XLEN-2:0], div_ok};
          counter <= counter - 1'b1;
        end
        default: begin
          if (!bus.kill) begin
            result_q    <= fin_result;
            zero_q      <= (fin_result == '0);
            out_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule
